// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM access controller
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } sram_state_e;

    // {write_en, sense_en} pairs driven to the macro
    localparam logic [1:0] CTRL_IDLE  = 2'b01;
    localparam logic [1:0] CTRL_WRITE = 2'b11;
    localparam logic [1:0] CTRL_READ  = 2'b00;

    localparam int N_ADDR_DEFAULT = 12;
    localparam int N_DATA_DEFAULT = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with remembered last grant
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic grant_update,
    output logic grant0,
    output logic grant1
);

    // resets to 1 so requester 0 wins the first tie
    logic last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant_update) begin
            last_grant <= grant1;
        end
    end

    assign grant0 = req0 & (~req1 | last_grant);
    assign grant1 = req1 & (~req0 | ~last_grant);

endmodule

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - two-requester sequencer generating the compiled SRAM macro clock and controls
module sram_access_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int N_addr = N_ADDR_DEFAULT,
    parameter int N_data = N_DATA_DEFAULT,
    parameter int T_HALF = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [N_addr-1:0] req0_addr,
    input  logic [N_data-1:0] req0_wdata,
    output logic              req0_rvalid,
    output logic [N_data-1:0] req0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [N_addr-1:0] req1_addr,
    input  logic [N_data-1:0] req1_wdata,
    output logic              req1_rvalid,
    output logic [N_data-1:0] req1_rdata,
    output logic              sram_clk,
    output logic [N_addr-1:0] sram_addr,
    output logic [N_data-1:0] sram_din,
    output logic              sram_write_en,
    output logic              sram_sense_en,
    input  logic [N_data-1:0] sram_dout,
    output logic              busy
);

    localparam int PW = $clog2(T_HALF) + 1;
    localparam logic [PW-1:0] PH_LOAD = PW'(T_HALF - 1);

    sram_state_e       state;
    sram_state_e       state_nxt;
    logic [PW-1:0]     phase;
    logic              phase_done;
    logic              owner;
    logic              cur_we;
    logic              next_we;
    logic              grant0;
    logic              grant1;
    logic              hs;
    logic              rd_done;
    logic [1:0]        ctrl;
    logic              sel_we;
    logic [N_addr-1:0] sel_addr;
    logic [N_data-1:0] sel_wdata;

    rr_arbiter2 u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0_valid),
        .req1         (req1_valid),
        .grant_update (hs),
        .grant0       (grant0),
        .grant1       (grant1)
    );

    // ready is gated by rst_n so nothing is offered while reset is held
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;
    assign hs         = req0_ready | req1_ready;

    assign sel_we    = grant1 ? req1_we    : req0_we;
    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;

    assign phase_done = (phase == '0);
    assign rd_done    = (state == ACTIVE) && phase_done && !cur_we;
    assign next_we    = hs ? sel_we : cur_we;
    assign busy       = (state != IDLE);

    assign sram_write_en = ctrl[1];
    assign sram_sense_en = ctrl[0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs)         state_nxt = SETUP;
            SETUP:   if (phase_done) state_nxt = ACTIVE;
            ACTIVE:  if (phase_done) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= '0;
            owner       <= 1'b0;
            cur_we      <= 1'b0;
            sram_addr   <= '0;
            sram_din    <= '0;
            sram_clk    <= 1'b0;
            ctrl        <= CTRL_IDLE;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                phase <= PH_LOAD;
            end else if (!phase_done) begin
                phase <= phase - 1'b1;
            end
            if (hs) begin
                owner     <= grant1;
                cur_we    <= sel_we;
                sram_addr <= sel_addr;
                sram_din  <= sel_wdata;
            end
            // macro pins are registered from the next state so they never glitch
            sram_clk <= (state_nxt == ACTIVE);
            if (state_nxt == SETUP || state_nxt == ACTIVE) begin
                ctrl <= next_we ? CTRL_WRITE : CTRL_READ;
            end else begin
                ctrl <= CTRL_IDLE;
            end
            req0_rvalid <= rd_done && !owner;
            req1_rvalid <= rd_done && owner;
            if (rd_done && !owner) req0_rdata <= sram_dout;
            if (rd_done && owner)  req1_rdata <= sram_dout;
        end
    end

endmodule
